tcdm_bank_responder: RTL

Target-side endpoint of the radix-2 butterfly TCDM network. It terminates one network output port with a small word-addressed memory bank. It accepts req/gnt transactions and returns read data exactly one cycle after the grant, which is the timing the routers' registered response-path select depends on. A configurable grant-stall generator lets benches exercise back-pressure and arbitration in the upstream routers.

---
 rtl/tcdm_bank_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/tcdm_bank_responder.sv
// TCDM target endpoint: a small word-addressed bank behind one network output
// port. Read data returns one cycle after grant. An optional stall generator
// withholds grants to create back-pressure for the upstream routers.
module tcdm_bank_responder #(
  parameter int unsigned AddWidth    = 8,
  parameter int unsigned MemAddWidth = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StallMode   = 0,
  parameter int unsigned StallPeriod = 4,
  parameter logic [7:0]  LfsrSeed    = 8'hA5,
  localparam int unsigned BeWidth      = DataWidth / 8,
  localparam int unsigned ReqDataWidth = 1 + BeWidth + DataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddWidth-1:0]     add_i,
  input  logic [ReqDataWidth-1:0] data_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic [15:0]             req_cnt_o,
  output logic [15:0]             stall_cnt_o
);

  localparam int unsigned NumWords = 2 ** MemAddWidth;
  localparam int unsigned PerW     = (StallPeriod > 2) ? $clog2(StallPeriod) : 1;
  localparam logic [PerW-1:0] PerLast = PerW'(StallPeriod - 1);
  // A zero seed would lock the LFSR, so it is bumped to 1.
  localparam logic [7:0] SeedEff = (LfsrSeed == 8'h00) ? 8'h01 : LfsrSeed;
  // Taps for x^8+x^6+x^5+x^4+1 on bits 7,5,4,3.
  localparam logic [7:0] LfsrTaps = 8'hB8;

  if (MemAddWidth > AddWidth) begin : g_chk_add
    $error("MemAddWidth must not exceed AddWidth");
  end
  if ((DataWidth % 8) != 0) begin : g_chk_dw
    $error("DataWidth must be a multiple of 8");
  end
  if ((StallMode == 1) && (StallPeriod < 2)) begin : g_chk_per
    $error("StallPeriod must be >= 2 in periodic stall mode");
  end

  logic [NumWords-1:0][BeWidth-1:0][7:0] mem_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [15:0]            req_cnt_q, stall_cnt_q;
  logic [PerW-1:0]        per_cnt_q;
  logic [7:0]             lfsr_q;
  logic                   stall;

  logic [MemAddWidth-1:0] idx;
  logic                   wen;
  logic [BeWidth-1:0]     be;
  logic [BeWidth-1:0][7:0] wdata;
  logic                   add_unused;

  assign idx   = add_i[AddWidth-1 -: MemAddWidth];
  assign wen   = data_i[ReqDataWidth-1];
  assign be    = data_i[DataWidth +: BeWidth];
  assign wdata = data_i[DataWidth-1:0];
  // Low address bits carry no information for a word-addressed bank.
  assign add_unused = ^add_i;

  // Stall decision is taken only from registered state.
  always_comb begin
    stall = 1'b0;
    if (StallMode == 1)      stall = (per_cnt_q == PerLast);
    else if (StallMode == 2) stall = lfsr_q[7];
  end

  assign gnt_o       = req_i & ~stall & rst_ni;
  assign rdata_o     = rdata_q;
  assign req_cnt_o   = req_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  // Free-running stall generators, independent of traffic.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      per_cnt_q <= '0;
      lfsr_q    <= SeedEff;
    end else begin
      per_cnt_q <= (per_cnt_q == PerLast) ? '0 : per_cnt_q + PerW'(1);
      lfsr_q    <= {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  // Bank access: read-before-write, byte-enabled writes, one access per grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      rdata_q <= '0;
    end else if (gnt_o) begin
      rdata_q <= mem_q[idx];
      if (wen) begin
        for (int b = 0; b < BeWidth; b++) begin
          if (be[b]) mem_q[idx][b] <= wdata[b];
        end
      end
    end
  end

  // Saturating transaction and stall-cycle counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (gnt_o && (req_cnt_q != 16'hFFFF)) req_cnt_q <= req_cnt_q + 16'd1;
      if (req_i && !gnt_o && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
